// File: rtl/seg7_enc_pkg.sv
// seg7_enc_pkg: glyph table and FSM state type for the 7-segment scan encoder.
// Glyphs are stored active-high, bit0=a .. bit6=g.
package seg7_enc_pkg;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  // Entry i (hex digit i) lives at [7*i+6:7*i].
  localparam logic [16*7-1:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_to_bin.sv
// seg7_to_bin: active-high segment pattern -> hex nibble.
// Unknown patterns give nibble 0 with illegal set.
module seg7_to_bin
  import seg7_enc_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Table search; glyphs are unique so at most one entry hits.
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TBL[7*i +: 7]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: collects N segment beats into a packed hex word.
// Define SEG7_ENC_ACTIVE_HIGH_EN for active-high seg_in (default active-low).
module seg7_scan_encoder
  import seg7_enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [6:0]     seg_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*4-1:0] num_all,
  output logic [N-1:0]   err_mask,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [6:0]       seg_hi;
  logic [3:0]       nib;
  logic             ill;

`ifdef SEG7_ENC_ACTIVE_HIGH_EN
  assign seg_hi = seg_in;
`else
  assign seg_hi = ~seg_in;
`endif

  seg7_to_bin u_dec (
    .seg     (seg_hi),
    .nibble  (nib),
    .illegal (ill)
  );

  assign in_ready = (state == COLLECT);
  assign out_err  = |err_mask;

  // Collect/hold FSM with digit index and registered word outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      num_all   <= '0;
      err_mask  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            for (int k = 0; k < N; k++) begin
              if (idx == IDX_W'(k)) begin
                num_all[4*k +: 4] <= nib;
                err_mask[k]       <= ill;
              end
            end
            if (idx == IDX_LAST) begin
              idx       <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            err_mask  <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder: directed scoreboard bench for seg7_scan_encoder.
// Default build (active-low segments), N=4.
module tb_seg7_scan_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] num_all;
  logic [3:0]  err_mask;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_scan_encoder #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_all   (num_all),
    .err_mask  (err_mask),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a word is taken when out_valid&&out_ready at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_word", 32'(num_all), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          check("num_all", 32'(num_all), 32'(e.num));
          check("err_mask", 32'(err_mask), 32'(e.err));
          check("out_err", 32'(out_err), 32'(|e.err));
        end
      end
    end
  end

  task automatic send_beat(logic [6:0] s, int gap);
    logic ok;
    ok = 1'b0;
    seg_in   = s;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("beat_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
    seg_in   = 7'h7F;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(string name);
    for (int t = 0; t < 20 && sbq.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(sbq.size()), 32'(0));
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_num_all", 32'(num_all), 32'(0));
    check("rst_err_mask", 32'(err_mask), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back word, latency check
    e.num = 16'h4321; e.err = 4'b0000; sbq.push_back(e);
    send_beat(7'h79, 0);
    send_beat(7'h24, 0);
    send_beat(7'h30, 0);
    check("valid_before_last", 32'(out_valid), 32'(0));
    send_beat(7'h19, 0);
    check("valid_after_last", 32'(out_valid), 32'(1));
    check("hold_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    check("collect_again", 32'(in_ready), 32'(1));
    check("valid_dropped", 32'(out_valid), 32'(0));
    drain("drain_w1");

    // Illegal glyph in digit 1: digits F, -, 8, 0
    e.num = 16'h080F; e.err = 4'b0010; sbq.push_back(e);
    send_beat(7'h0E, 0);
    send_beat(7'h7F, 0);
    send_beat(7'h00, 0);
    send_beat(7'h40, 0);
    drain("drain_w2");
    check("err_cleared", 32'(err_mask), 32'(0));

    // Backpressure: in_valid held through HOLD must not be consumed
    out_ready = 1'b0;
    e.num = 16'h7654; e.err = 4'b0000; sbq.push_back(e);
    send_beat(7'h19, 0);
    send_beat(7'h12, 0);
    send_beat(7'h02, 0);
    send_beat(7'h78, 0);
    seg_in   = 7'h79;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_num", 32'(num_all), 32'h7654);
    end
    e.num = 16'h4321; e.err = 4'b0000; sbq.push_back(e);
    out_ready = 1'b1;
    send_beat(7'h79, 0);
    send_beat(7'h24, 0);
    send_beat(7'h30, 0);
    send_beat(7'h19, 0);
    drain("drain_bp");

    // Gapped beats
    e.num = 16'h4321; e.err = 4'b0000; sbq.push_back(e);
    send_beat(7'h79, 2);
    send_beat(7'h24, 2);
    send_beat(7'h30, 2);
    send_beat(7'h19, 2);
    drain("drain_gap");

    // Reset mid-word discards partial digits
    send_beat(7'h79, 0);
    send_beat(7'h24, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_num", 32'(num_all), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    e.num = 16'h0000; e.err = 4'b0000; sbq.push_back(e);
    send_beat(7'h40, 0);
    send_beat(7'h40, 0);
    send_beat(7'h40, 0);
    check("midrst_no_early", 32'(out_valid), 32'(0));
    send_beat(7'h40, 0);
    drain("drain_rst");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
